// File: rtl/rs_custom.sv
// rs_custom: reservation station with operand wakeup, speculative kill and in-order-by-index issue
module rs_custom #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int SPEC_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_src1,
    input  logic [DATA_W-1:0]            wr_src2,
    input  logic                         wr_vld1,
    input  logic                         wr_vld2,
    input  logic [DATA_W-1:0]            wr_imm,
    input  logic [TAG_W-1:0]             wr_rrftag,
    input  logic                         wr_dstval,
    input  logic [6:0]                   wr_funct7,
    input  logic [2:0]                   wr_funct3,
    input  logic [24:0]                  wr_passbits,
    input  logic [SPEC_W-1:0]            wr_spectag,
    input  logic                         wr_specbit,
    input  logic                         wb0_en,
    input  logic [TAG_W-1:0]             wb0_tag,
    input  logic [DATA_W-1:0]            wb0_data,
    input  logic                         wb1_en,
    input  logic [TAG_W-1:0]             wb1_tag,
    input  logic [DATA_W-1:0]            wb1_data,
    input  logic                         prmiss,
    input  logic                         prsuccess,
    input  logic [SPEC_W-1:0]            spectagfix,
    input  logic                         iss_stall,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   busy_cnt,
    output logic                         iss_valid,
    output logic [DATA_W-1:0]            iss_src1,
    output logic [DATA_W-1:0]            iss_src2,
    output logic [DATA_W-1:0]            iss_imm,
    output logic [TAG_W-1:0]             iss_rrftag,
    output logic                         iss_dstval,
    output logic [6:0]                   iss_funct7,
    output logic [2:0]                   iss_funct3,
    output logic [24:0]                  iss_passbits,
    output logic [SPEC_W-1:0]            iss_spectag,
    output logic                         iss_specbit
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid, rdy1, rdy2, dstval, specbit;
    logic [DATA_W-1:0] src1 [DEPTH];
    logic [DATA_W-1:0] src2 [DEPTH];
    logic [DATA_W-1:0] imm [DEPTH];
    logic [TAG_W-1:0]  rrftag [DEPTH];
    logic [6:0]        funct7 [DEPTH];
    logic [2:0]        funct3 [DEPTH];
    logic [24:0]       passbits [DEPTH];
    logic [SPEC_W-1:0] spectag [DEPTH];

    logic [DEPTH-1:0] kill, ready, next_valid;
    logic [IDX_W-1:0] sel, free_idx;
    logic [CNT_W-1:0] next_cnt;
    logic             success, wr_kill, wr_ok, iss_fire;
    logic             w_rdy1, w_rdy2;
    logic [DATA_W-1:0] w_src1, w_src2;
    logic [SPEC_W-1:0] w_spectag;
    logic              w_specbit;

    // prmiss outranks prsuccess when both arrive together
    assign success  = prsuccess & ~prmiss;
    assign wr_kill  = prmiss & wr_specbit & |(wr_spectag & spectagfix);
    assign wr_ok    = wr_en & ~full & ~wr_kill;
    assign iss_fire = iss_valid & ~iss_stall;
    assign full     = busy_cnt == CNT_W'(DEPTH);

    // Incoming operands may be satisfied by a broadcast in the same cycle; wb0 wins ties
    assign w_rdy1 = wr_vld1 | (wb0_en & wb0_tag == wr_src1[TAG_W-1:0]) | (wb1_en & wb1_tag == wr_src1[TAG_W-1:0]);
    assign w_rdy2 = wr_vld2 | (wb0_en & wb0_tag == wr_src2[TAG_W-1:0]) | (wb1_en & wb1_tag == wr_src2[TAG_W-1:0]);
    assign w_src1 = wr_vld1 ? wr_src1 : (wb0_en & wb0_tag == wr_src1[TAG_W-1:0]) ? wb0_data :
                    (wb1_en & wb1_tag == wr_src1[TAG_W-1:0]) ? wb1_data : wr_src1;
    assign w_src2 = wr_vld2 ? wr_src2 : (wb0_en & wb0_tag == wr_src2[TAG_W-1:0]) ? wb0_data :
                    (wb1_en & wb1_tag == wr_src2[TAG_W-1:0]) ? wb1_data : wr_src2;
    assign w_spectag = success ? (wr_spectag & ~spectagfix) : wr_spectag;
    assign w_specbit = success ? (wr_specbit & |(wr_spectag & ~spectagfix)) : wr_specbit;

    // Kill/ready masks, lowest-index selection for issue and allocation, next occupancy
    always_comb begin
        sel = '0;
        free_idx = '0;
        iss_valid = 1'b0;
        next_cnt = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            kill[i]  = prmiss & specbit[i] & |(spectag[i] & spectagfix);
            ready[i] = valid[i] & rdy1[i] & rdy2[i] & ~kill[i];
            if (ready[i]) begin
                iss_valid = 1'b1;
                sel = IDX_W'(i);
            end
            if (!valid[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            next_valid[i] = (valid[i] & ~kill[i] & ~(iss_fire & sel == IDX_W'(i))) | (wr_ok & free_idx == IDX_W'(i));
            next_cnt = next_cnt + CNT_W'(next_valid[i]);
        end
    end

    assign iss_src1     = src1[sel];
    assign iss_src2     = src2[sel];
    assign iss_imm      = imm[sel];
    assign iss_rrftag   = rrftag[sel];
    assign iss_dstval   = dstval[sel];
    assign iss_funct7   = funct7[sel];
    assign iss_funct3   = funct3[sel];
    assign iss_passbits = passbits[sel];
    assign iss_spectag  = spectag[sel];
    assign iss_specbit  = specbit[sel];

    // Entry storage: allocation, operand wakeup and speculation-tag clearing
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            busy_cnt <= '0;
        end else begin
            valid    <= next_valid;
            busy_cnt <= next_cnt;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && free_idx == IDX_W'(i)) begin
                    src1[i]     <= w_src1;
                    src2[i]     <= w_src2;
                    rdy1[i]     <= w_rdy1;
                    rdy2[i]     <= w_rdy2;
                    imm[i]      <= wr_imm;
                    rrftag[i]   <= wr_rrftag;
                    dstval[i]   <= wr_dstval;
                    funct7[i]   <= wr_funct7;
                    funct3[i]   <= wr_funct3;
                    passbits[i] <= wr_passbits;
                    spectag[i]  <= w_spectag;
                    specbit[i]  <= w_specbit;
                end else if (valid[i]) begin
                    if (!rdy1[i] && wb0_en && wb0_tag == src1[i][TAG_W-1:0]) begin
                        src1[i] <= wb0_data;
                        rdy1[i] <= 1'b1;
                    end else if (!rdy1[i] && wb1_en && wb1_tag == src1[i][TAG_W-1:0]) begin
                        src1[i] <= wb1_data;
                        rdy1[i] <= 1'b1;
                    end
                    if (!rdy2[i] && wb0_en && wb0_tag == src2[i][TAG_W-1:0]) begin
                        src2[i] <= wb0_data;
                        rdy2[i] <= 1'b1;
                    end else if (!rdy2[i] && wb1_en && wb1_tag == src2[i][TAG_W-1:0]) begin
                        src2[i] <= wb1_data;
                        rdy2[i] <= 1'b1;
                    end
                    if (success) begin
                        spectag[i] <= spectag[i] & ~spectagfix;
                        specbit[i] <= specbit[i] & |(spectag[i] & ~spectagfix);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_custom.sv
// tb_rs_custom: directed self-checking bench for rs_custom
module tb_rs_custom;
    logic        clk = 1'b0;
    logic        reset, wr_en, wr_vld1, wr_vld2, wr_dstval, wr_specbit;
    logic [31:0] wr_src1, wr_src2, wr_imm, wb0_data, wb1_data;
    logic [5:0]  wr_rrftag, wb0_tag, wb1_tag;
    logic [6:0]  wr_funct7;
    logic [2:0]  wr_funct3;
    logic [24:0] wr_passbits;
    logic [4:0]  wr_spectag, spectagfix;
    logic        wb0_en, wb1_en, prmiss, prsuccess, iss_stall;
    logic        full, iss_valid, iss_dstval, iss_specbit;
    logic [2:0]  busy_cnt;
    logic [31:0] iss_src1, iss_src2, iss_imm;
    logic [5:0]  iss_rrftag;
    logic [6:0]  iss_funct7;
    logic [2:0]  iss_funct3;
    logic [24:0] iss_passbits;
    logic [4:0]  iss_spectag;
    int checks = 0;
    int errors = 0;

    rs_custom dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_src1(wr_src1), .wr_src2(wr_src2),
        .wr_vld1(wr_vld1), .wr_vld2(wr_vld2), .wr_imm(wr_imm), .wr_rrftag(wr_rrftag),
        .wr_dstval(wr_dstval), .wr_funct7(wr_funct7), .wr_funct3(wr_funct3),
        .wr_passbits(wr_passbits), .wr_spectag(wr_spectag), .wr_specbit(wr_specbit),
        .wb0_en(wb0_en), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix), .iss_stall(iss_stall),
        .full(full), .busy_cnt(busy_cnt), .iss_valid(iss_valid), .iss_src1(iss_src1),
        .iss_src2(iss_src2), .iss_imm(iss_imm), .iss_rrftag(iss_rrftag), .iss_dstval(iss_dstval),
        .iss_funct7(iss_funct7), .iss_funct3(iss_funct3), .iss_passbits(iss_passbits),
        .iss_spectag(iss_spectag), .iss_specbit(iss_specbit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; wr_en = 0; wr_vld1 = 0; wr_vld2 = 0; wr_dstval = 0; wr_specbit = 0;
        wr_src1 = 0; wr_src2 = 0; wr_imm = 0; wr_rrftag = 0; wr_funct7 = 0; wr_funct3 = 0;
        wr_passbits = 0; wr_spectag = 0; wb0_en = 0; wb0_tag = 0; wb0_data = 0;
        wb1_en = 0; wb1_tag = 0; wb1_data = 0; prmiss = 0; prsuccess = 0; spectagfix = 0;
    endtask

    task automatic set_wr(input logic [31:0] s1, input logic v1, input logic [31:0] s2, input logic v2,
                          input logic [5:0] tag, input logic [4:0] st, input logic sb);
        wr_en = 1; wr_src1 = s1; wr_vld1 = v1; wr_src2 = s2; wr_vld2 = v2;
        wr_rrftag = tag; wr_spectag = st; wr_specbit = sb;
    endtask

    task automatic test_reset();
        clear_inputs();
        iss_stall = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
        checks++; if (busy_cnt !== 3'd0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy_cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", full); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", iss_valid); end
    endtask

    task automatic test_basic();
        set_wr(32'd5, 1, 32'd7, 1, 6'd3, 5'd0, 0);
        #1;
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_write_cycle got %0d exp 0", iss_valid); end
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", iss_valid); end
        checks++; if (iss_src1 !== 32'd5) begin errors++; $display("FAIL basic_src1 got %0h exp 5", iss_src1); end
        checks++; if (iss_src2 !== 32'd7) begin errors++; $display("FAIL basic_src2 got %0h exp 7", iss_src2); end
        checks++; if (iss_rrftag !== 6'd3) begin errors++; $display("FAIL basic_rrftag got %0d exp 3", iss_rrftag); end
        checks++; if (busy_cnt !== 3'd1) begin errors++; $display("FAIL basic_busy1 got %0d exp 1", busy_cnt); end
        tick();
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_after got %0d exp 0", iss_valid); end
        checks++; if (busy_cnt !== 3'd0) begin errors++; $display("FAIL basic_busy0 got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_wakeup();
        set_wr(32'd1, 1, 32'd9, 0, 6'd4, 5'd0, 0);
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0d exp 0", iss_valid); end
        tick();
        wb1_en = 1; wb1_tag = 6'd9; wb1_data = 32'hDEAD;
        #1;
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_bcast_cycle got %0d exp 0", iss_valid); end
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got %0d exp 1", iss_valid); end
        checks++; if (iss_src2 !== 32'hDEAD) begin errors++; $display("FAIL wake_src2 got %0h exp dead", iss_src2); end
        tick();
        set_wr(32'd4, 0, 32'd2, 1, 6'd5, 5'd0, 0);
        tick();
        clear_inputs();
        wb0_en = 1; wb0_tag = 6'd4; wb0_data = 32'h111;
        wb1_en = 1; wb1_tag = 6'd4; wb1_data = 32'h222;
        tick();
        clear_inputs();
        checks++; if (iss_src1 !== 32'h111) begin errors++; $display("FAIL wake_wb0_prio got %0h exp 111", iss_src1); end
        tick();
        set_wr(32'd12, 0, 32'd2, 1, 6'd6, 5'd0, 0);
        wb0_en = 1; wb0_tag = 6'd12; wb0_data = 32'hABC;
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %0d exp 1", iss_valid); end
        checks++; if (iss_src1 !== 32'hABC) begin errors++; $display("FAIL bypass_src1 got %0h exp abc", iss_src1); end
        tick();
        checks++; if (busy_cnt !== 3'd0) begin errors++; $display("FAIL wake_drain got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_full();
        iss_stall = 1;
        for (int k = 0; k < 4; k++) begin
            set_wr(32'd0, 1, 32'd0, 1, 6'(10 + k), 5'd0, 0);
            tick();
        end
        clear_inputs();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0d exp 1", full); end
        checks++; if (busy_cnt !== 3'd4) begin errors++; $display("FAIL full_busy got %0d exp 4", busy_cnt); end
        set_wr(32'd0, 1, 32'd0, 1, 6'd20, 5'd0, 0);
        tick();
        clear_inputs();
        checks++; if (busy_cnt !== 3'd4) begin errors++; $display("FAIL full_ignore got %0d exp 4", busy_cnt); end
        checks++; if (iss_rrftag !== 6'd10) begin errors++; $display("FAIL full_stall_stable got %0d exp 10", iss_rrftag); end
        iss_stall = 0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (iss_valid !== 1'b1 || iss_rrftag !== 6'(10 + k)) begin errors++; $display("FAIL full_order%0d got v=%0d tag=%0d exp v=1 tag=%0d", k, iss_valid, iss_rrftag, 10 + k); end
            tick();
        end
        checks++; if (iss_valid !== 1'b0 || busy_cnt !== 3'd0) begin errors++; $display("FAIL full_drain got v=%0d busy=%0d exp 0 0", iss_valid, busy_cnt); end
    endtask

    task automatic test_kill();
        iss_stall = 1;
        set_wr(32'd0, 1, 32'd0, 1, 6'd1, 5'b00010, 1);
        tick();
        set_wr(32'd0, 1, 32'd0, 1, 6'd2, 5'b00100, 1);
        tick();
        clear_inputs();
        checks++; if (iss_rrftag !== 6'd1) begin errors++; $display("FAIL kill_pre got %0d exp 1", iss_rrftag); end
        prmiss = 1; spectagfix = 5'b00010;
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_rrftag !== 6'd2) begin errors++; $display("FAIL kill_mask got v=%0d tag=%0d exp v=1 tag=2", iss_valid, iss_rrftag); end
        tick();
        clear_inputs();
        checks++; if (busy_cnt !== 3'd1) begin errors++; $display("FAIL kill_busy got %0d exp 1", busy_cnt); end
        checks++; if (iss_rrftag !== 6'd2) begin errors++; $display("FAIL kill_survivor got %0d exp 2", iss_rrftag); end
        iss_stall = 0;
        tick();
        checks++; if (iss_valid !== 1'b0 || busy_cnt !== 3'd0) begin errors++; $display("FAIL kill_drain got v=%0d busy=%0d exp 0 0", iss_valid, busy_cnt); end
        iss_stall = 1;
        set_wr(32'd0, 1, 32'd0, 1, 6'd7, 5'b00010, 1);
        prmiss = 1; spectagfix = 5'b00010;
        tick();
        clear_inputs();
        checks++; if (busy_cnt !== 3'd0) begin errors++; $display("FAIL kill_incoming got %0d exp 0", busy_cnt); end
        set_wr(32'd0, 1, 32'd0, 1, 6'd8, 5'b00010, 0);
        prmiss = 1; spectagfix = 5'b00010;
        tick();
        clear_inputs();
        checks++; if (busy_cnt !== 3'd1 || iss_rrftag !== 6'd8) begin errors++; $display("FAIL kill_nonspec got busy=%0d tag=%0d exp 1 8", busy_cnt, iss_rrftag); end
        iss_stall = 0;
        tick();
    endtask

    task automatic test_success();
        iss_stall = 1;
        set_wr(32'd0, 1, 32'd0, 1, 6'd5, 5'b00010, 1);
        tick();
        set_wr(32'd0, 1, 32'd0, 1, 6'd6, 5'b00110, 1);
        tick();
        clear_inputs();
        prsuccess = 1; spectagfix = 5'b00010;
        tick();
        clear_inputs();
        checks++; if (iss_specbit !== 1'b0 || iss_spectag !== 5'd0) begin errors++; $display("FAIL succ_a got sb=%0d st=%b exp 0 00000", iss_specbit, iss_spectag); end
        iss_stall = 0;
        tick();
        checks++; if (iss_rrftag !== 6'd6 || iss_specbit !== 1'b1 || iss_spectag !== 5'b00100) begin errors++; $display("FAIL succ_b got tag=%0d sb=%0d st=%b exp 6 1 00100", iss_rrftag, iss_specbit, iss_spectag); end
        tick();
        iss_stall = 1;
        set_wr(32'd0, 1, 32'd0, 1, 6'd9, 5'b00100, 1);
        prmiss = 1; prsuccess = 1; spectagfix = 5'b00010;
        tick();
        clear_inputs();
        checks++; if (iss_spectag !== 5'b00100 || iss_specbit !== 1'b1) begin errors++; $display("FAIL succ_prio got sb=%0d st=%b exp 1 00100", iss_specbit, iss_spectag); end
        iss_stall = 0;
        tick();
    endtask

    task automatic test_reset_busy();
        iss_stall = 1;
        for (int k = 0; k < 3; k++) begin
            set_wr(32'd0, 1, 32'd0, 1, 6'(k), 5'd0, 0);
            tick();
        end
        clear_inputs();
        checks++; if (busy_cnt !== 3'd3) begin errors++; $display("FAIL rst3_pre got %0d exp 3", busy_cnt); end
        reset = 1;
        set_wr(32'd0, 1, 32'd0, 1, 6'd30, 5'd0, 0);
        tick();
        clear_inputs();
        checks++; if (busy_cnt !== 3'd0 || full !== 1'b0 || iss_valid !== 1'b0) begin errors++; $display("FAIL rst3_post got busy=%0d full=%0d v=%0d exp 0 0 0", busy_cnt, full, iss_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_kill();
        test_success();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
